// File: rtl/keccak_pad_pkg.sv
// Shared state type, pad constants and byte-mask helper for the Keccak padder.
// Build option: define KECCAK_PAD_SHA3_EN for the SHA-3 domain pad byte (0x06) instead of 0x01.
package keccak_pad_pkg;

   typedef enum logic [1:0] {StAccept, StPad, StFull, StDone} pad_state_e;

`ifdef KECCAK_PAD_SHA3_EN
   localparam logic [7:0] PAD_START = 8'h06;
`else
   localparam logic [7:0] PAD_START = 8'h01;
`endif
   localparam logic [7:0] PAD_END = 8'h80;

   // Bit i is set when byte i (counted from the MSB end) carries message data.
   function automatic logic [7:0] byte_mask(input logic [2:0] byte_num);
      return 8'((16'd1 << byte_num) - 16'd1);
   endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Builds the padded last message word: valid bytes, pad start byte, zeros, and the
// closing 0x80 when the word lands in the final slot of the block.
module keccak_pad_word
   import keccak_pad_pkg::*;
#(
   parameter int IN_W = 32,
   localparam int BN_W = $clog2(IN_W / 8),
   localparam int NB = IN_W / 8
) (
   input  logic [IN_W-1:0] word_i,
   input  logic [BN_W-1:0] byte_num_i,
   input  logic            is_final_slot_i,
   output logic [IN_W-1:0] word_o
);

   logic [7:0] mask;

   always_comb begin
      mask   = byte_mask(3'(byte_num_i));
      word_o = '0;
      for (int i = 0; i < NB; i++) begin
         if (mask[i]) begin
            word_o[IN_W-1-8*i -: 8] = word_i[IN_W-1-8*i -: 8];
         end else if (int'(byte_num_i) == i) begin
            word_o[IN_W-1-8*i -: 8] = PAD_START;
         end
      end
      if (is_final_slot_i) begin
         word_o[7:0] = word_o[7:0] | PAD_END;
      end
   end

endmodule

// File: rtl/keccak_padder_param.sv
// Keccak pad10*1 padder with configurable word width and rate; assembles RATE-bit blocks
// and holds each one until f_ack. Pad byte selected by KECCAK_PAD_SHA3_EN.
module keccak_padder_param
   import keccak_pad_pkg::*;
#(
   parameter int IN_W = 32,
   parameter int RATE = 576,
   localparam int BN_W = $clog2(IN_W / 8),
   localparam int WORDS = RATE / IN_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [IN_W-1:0] in,
   input  logic            in_ready,
   input  logic            is_last,
   input  logic [BN_W-1:0] byte_num,
   output logic            buffer_full,
   output logic [RATE-1:0] out,
   output logic            out_ready,
   output logic            out_last,
   input  logic            f_ack
);

   localparam int CNT_W = $clog2(WORDS + 1);

   pad_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [RATE-1:0]  out_q, out_d;
   logic             out_last_q, out_last_d;
   logic             final_slot;
   logic [IN_W-1:0]  pad_word;
   logic [IN_W-1:0]  slot_word;
   logic             slot_wr;

   assign final_slot = (count_q == CNT_W'(WORDS - 1));

   keccak_pad_word #(
      .IN_W(IN_W)
   ) u_pad_word (
      .word_i         (in),
      .byte_num_i     (byte_num),
      .is_final_slot_i(final_slot),
      .word_o         (pad_word)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      out_d      = out_q;
      out_last_d = out_last_q;
      slot_wr    = 1'b0;
      slot_word  = '0;
      unique case (state_q)
         StAccept: begin
            if (in_ready) begin
               slot_wr   = 1'b1;
               slot_word = is_last ? pad_word : in;
               if (final_slot) begin
                  state_d    = StFull;
                  out_last_d = is_last;
               end else begin
                  count_d = count_q + CNT_W'(1);
                  if (is_last) state_d = StPad;
               end
            end
         end
         StPad: begin
            slot_wr = 1'b1;
            if (final_slot) begin
               slot_word  = IN_W'(PAD_END);
               state_d    = StFull;
               out_last_d = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         StFull: begin
            // The pad byte always fits in the last word, so a non-final block resumes input.
            if (f_ack) begin
               count_d    = '0;
               out_d      = '0;
               out_last_d = 1'b0;
               state_d    = out_last_q ? StDone : StAccept;
            end
         end
         StDone: begin
         end
         default: state_d = StAccept;
      endcase
      if (slot_wr) begin
         for (int k = 0; k < WORDS; k++) begin
            if (count_q == CNT_W'(k)) out_d[RATE-1-k*IN_W -: IN_W] = slot_word;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StAccept;
         count_q    <= '0;
         out_q      <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         out_q      <= out_d;
         out_last_q <= out_last_d;
      end
   end

   assign out         = out_q;
   assign out_last    = out_last_q;
   assign buffer_full = (state_q != StAccept);
   assign out_ready   = (state_q == StFull);

endmodule
